// File: rtl/marker_decoder.sv
// marker_decoder: receive-side decoder for the 16-bit DTC->ROC command-marker link.
// Classifies each received word, pairs double markers with their complements,
// validates the 1C15/1CEA/seq retransmission triple and emits one-cycle strobes.
// Ports:
//   HCLK, HRESETN           clock, async active-low reset
//   RX_DATA[15:0]           received word
//   RX_KCHAR[1:0]           K flags (11 comma, 10 command, 00 data)
//   CNT_CLEAR               synchronous clear of both counters
//   *_MARKER, DCS_REQUEST,  one-cycle strobes (latency 1 after the completing word)
//   UNDEF_CMD, RETRANS_REQ
//   RETRANS_SEQ[3:0]        sequence of last good retransmission request (held)
//   ERR, ERR_CODE[3:0]      error strobe and last error code (held)
//   MARKER_CNT[15:0]        good-marker count (wraps)
//   ERR_CNT[7:0]            error count (saturates)
module marker_decoder (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic [15:0] RX_DATA,
  input  logic [1:0]  RX_KCHAR,
  input  logic        CNT_CLEAR,
  output logic        CLOCK_MARKER,
  output logic        EVENT_MARKER,
  output logic        LOOPBACK_MARKER,
  output logic        DIAG_MARKER,
  output logic        TIMEOUT_MARKER,
  output logic        DCS_REQUEST,
  output logic        UNDEF_CMD,
  output logic        RETRANS_REQ,
  output logic [3:0]  RETRANS_SEQ,
  output logic        ERR,
  output logic [3:0]  ERR_CODE,
  output logic [15:0] MARKER_CNT,
  output logic [7:0]  ERR_CNT
);

  localparam int unsigned MCNT_W = 16;
  localparam int unsigned ECNT_W = 8;

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WAIT_CLK_CMP = 3'd1;
  localparam logic [2:0] WAIT_EVT_CMP = 3'd2;
  localparam logic [2:0] WAIT_RT_CMP  = 3'd3;
  localparam logic [2:0] WAIT_RT_SEQ  = 3'd4;

  localparam logic [3:0] E_MISSING_CMP = 4'd1;
  localparam logic [3:0] E_WRONG_CMP   = 4'd2;
  localparam logic [3:0] E_UNPAIRED    = 4'd3;
  localparam logic [3:0] E_SEQ_MISM    = 4'd4;
  localparam logic [3:0] E_MISSING_SEQ = 4'd5;
  localparam logic [3:0] E_ILLEGAL     = 4'd6;

  logic [2:0] state, state_nxt;

  logic is_comma_c, is_cmd_c, is_data_c, is_illegal_c, nib_equal_c;

  logic clk_nxt, evt_nxt, lb_nxt, diag_nxt, to_nxt, dcs_nxt, undef_nxt, rt_nxt, err_nxt;
  logic [3:0] seq_nxt, code_nxt;
  logic good_c;

  // Word classification
  assign is_comma_c   = (RX_KCHAR == 2'b11) && (RX_DATA == 16'hBC3C);
  assign is_cmd_c     = (RX_KCHAR == 2'b10) && (RX_DATA[15:8] == 8'h1C);
  assign is_data_c    = (RX_KCHAR == 2'b00);
  assign is_illegal_c = !(is_comma_c || is_cmd_c || is_data_c);
  assign nib_equal_c  = (RX_DATA[15:12] == RX_DATA[11:8]) &&
                        (RX_DATA[11:8]  == RX_DATA[7:4])  &&
                        (RX_DATA[7:4]   == RX_DATA[3:0]);

  // State register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and next-output decode; every pending state falls back to IDLE
  always_comb begin
    state_nxt = IDLE;
    clk_nxt   = 1'b0;
    evt_nxt   = 1'b0;
    lb_nxt    = 1'b0;
    diag_nxt  = 1'b0;
    to_nxt    = 1'b0;
    dcs_nxt   = 1'b0;
    undef_nxt = 1'b0;
    rt_nxt    = 1'b0;
    err_nxt   = 1'b0;
    seq_nxt   = RETRANS_SEQ;
    code_nxt  = ERR_CODE;
    case (state)
      IDLE: begin
        if (is_illegal_c) begin
          err_nxt = 1'b1; code_nxt = E_ILLEGAL;
        end else if (is_cmd_c) begin
          case (RX_DATA[7:0])
            8'h11: state_nxt = WAIT_CLK_CMP;
            8'h10: state_nxt = WAIT_EVT_CMP;
            8'h15: state_nxt = WAIT_RT_CMP;
            8'h12: lb_nxt    = 1'b1;
            8'h13: diag_nxt  = 1'b1;
            8'h14: to_nxt    = 1'b1;
            8'h00: dcs_nxt   = 1'b1;
            8'hEE, 8'hEF, 8'hEA, 8'hED: begin
              err_nxt = 1'b1; code_nxt = E_UNPAIRED;
            end
            default: undef_nxt = 1'b1;
          endcase
        end
      end
      WAIT_CLK_CMP, WAIT_EVT_CMP: begin
        if (is_illegal_c) begin
          err_nxt = 1'b1; code_nxt = E_ILLEGAL;
        end else if (is_cmd_c) begin
          if ((state == WAIT_CLK_CMP) && (RX_DATA[7:0] == 8'hEE))      clk_nxt = 1'b1;
          else if ((state == WAIT_EVT_CMP) && (RX_DATA[7:0] == 8'hEF)) evt_nxt = 1'b1;
          else begin
            err_nxt = 1'b1; code_nxt = E_WRONG_CMP;
          end
        end else begin
          err_nxt = 1'b1; code_nxt = E_MISSING_CMP;
        end
      end
      WAIT_RT_CMP: begin
        if (is_illegal_c) begin
          err_nxt = 1'b1; code_nxt = E_ILLEGAL;
        end else if (is_cmd_c) begin
          if (RX_DATA[7:0] == 8'hEA) state_nxt = WAIT_RT_SEQ;
          else begin
            err_nxt = 1'b1; code_nxt = E_WRONG_CMP;
          end
        end else begin
          err_nxt = 1'b1; code_nxt = E_MISSING_CMP;
        end
      end
      WAIT_RT_SEQ: begin
        if (is_illegal_c) begin
          err_nxt = 1'b1; code_nxt = E_ILLEGAL;
        end else if (is_data_c) begin
          if (nib_equal_c) begin
            rt_nxt = 1'b1; seq_nxt = RX_DATA[3:0];
          end else begin
            err_nxt = 1'b1; code_nxt = E_SEQ_MISM;
          end
        end else begin
          err_nxt = 1'b1; code_nxt = E_MISSING_SEQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign good_c = clk_nxt | evt_nxt | lb_nxt | diag_nxt | to_nxt | rt_nxt;

  // Registered outputs and counters; clear has priority over increment
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      CLOCK_MARKER    <= 1'b0;
      EVENT_MARKER    <= 1'b0;
      LOOPBACK_MARKER <= 1'b0;
      DIAG_MARKER     <= 1'b0;
      TIMEOUT_MARKER  <= 1'b0;
      DCS_REQUEST     <= 1'b0;
      UNDEF_CMD       <= 1'b0;
      RETRANS_REQ     <= 1'b0;
      RETRANS_SEQ     <= 4'd0;
      ERR             <= 1'b0;
      ERR_CODE        <= 4'd0;
      MARKER_CNT      <= '0;
      ERR_CNT         <= '0;
    end else begin
      CLOCK_MARKER    <= clk_nxt;
      EVENT_MARKER    <= evt_nxt;
      LOOPBACK_MARKER <= lb_nxt;
      DIAG_MARKER     <= diag_nxt;
      TIMEOUT_MARKER  <= to_nxt;
      DCS_REQUEST     <= dcs_nxt;
      UNDEF_CMD       <= undef_nxt;
      RETRANS_REQ     <= rt_nxt;
      RETRANS_SEQ     <= seq_nxt;
      ERR             <= err_nxt;
      ERR_CODE        <= code_nxt;
      if (CNT_CLEAR)   MARKER_CNT <= '0;
      else if (good_c) MARKER_CNT <= MARKER_CNT + MCNT_W'(1);
      if (CNT_CLEAR)                         ERR_CNT <= '0;
      else if (err_nxt && (ERR_CNT != '1))   ERR_CNT <= ERR_CNT + ECNT_W'(1);
    end
  end

endmodule

// File: tb/tb_marker_decoder.sv
// Self-checking bench for marker_decoder: directed test-plan sequences with literal
// expectations, then randomized word streams checked against a sequence-level model.
module tb_marker_decoder;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic [15:0] RX_DATA = 16'hBC3C;
  logic [1:0]  RX_KCHAR = 2'b11;
  logic        CNT_CLEAR = 1'b0;
  logic        CLOCK_MARKER, EVENT_MARKER, LOOPBACK_MARKER, DIAG_MARKER, TIMEOUT_MARKER;
  logic        DCS_REQUEST, UNDEF_CMD, RETRANS_REQ, ERR;
  logic [3:0]  RETRANS_SEQ, ERR_CODE;
  logic [15:0] MARKER_CNT;
  logic [7:0]  ERR_CNT;

  int total = 0;
  int bad = 0;

  marker_decoder dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .RX_DATA(RX_DATA), .RX_KCHAR(RX_KCHAR),
    .CNT_CLEAR(CNT_CLEAR), .CLOCK_MARKER(CLOCK_MARKER), .EVENT_MARKER(EVENT_MARKER),
    .LOOPBACK_MARKER(LOOPBACK_MARKER), .DIAG_MARKER(DIAG_MARKER),
    .TIMEOUT_MARKER(TIMEOUT_MARKER), .DCS_REQUEST(DCS_REQUEST), .UNDEF_CMD(UNDEF_CMD),
    .RETRANS_REQ(RETRANS_REQ), .RETRANS_SEQ(RETRANS_SEQ), .ERR(ERR), .ERR_CODE(ERR_CODE),
    .MARKER_CNT(MARKER_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Strobe vector order: clk, evt, lb, diag, to, dcs, undef, rt, err
  logic [8:0]  e_str = '0;
  logic [3:0]  e_seq = '0;
  logic [3:0]  e_code = '0;
  logic [15:0] e_mcnt = '0;
  logic [7:0]  e_ecnt = '0;
  logic [15:0] pend[$];
  int          ec;
  logic        m_comma, m_cmd, m_data, m_bad;
  logic [7:0]  lo, want_lo;
  logic [15:0] d;

  always @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      pend.delete();
      e_str = '0; e_seq = '0; e_code = '0; e_mcnt = '0; e_ecnt = '0;
    end else begin
      d = RX_DATA;
      lo = d[7:0];
      m_comma = (RX_KCHAR == 2'b11) && (d == 16'hBC3C);
      m_cmd   = (RX_KCHAR == 2'b10) && (d[15:8] == 8'h1C);
      m_data  = (RX_KCHAR == 2'b00);
      m_bad   = !(m_comma || m_cmd || m_data);
      e_str = '0;
      ec = 0;
      if (pend.size() == 0) begin
        if (m_bad) ec = 6;
        else if (m_cmd) begin
          if (lo == 8'h11 || lo == 8'h10 || lo == 8'h15) pend.push_back(d);
          else if (lo == 8'h12) e_str[6] = 1'b1;
          else if (lo == 8'h13) e_str[5] = 1'b1;
          else if (lo == 8'h14) e_str[4] = 1'b1;
          else if (lo == 8'h00) e_str[3] = 1'b1;
          else if (lo == 8'hEE || lo == 8'hEF || lo == 8'hEA || lo == 8'hED) ec = 3;
          else e_str[2] = 1'b1;
        end
      end else if (pend.size() == 1) begin
        // complement of the first word is its low byte inverted
        want_lo = ~pend[0][7:0];
        if (m_bad) ec = 6;
        else if (m_cmd) begin
          if (lo != want_lo) ec = 2;
          else if (pend[0] == 16'h1C11) e_str[8] = 1'b1;
          else if (pend[0] == 16'h1C10) e_str[7] = 1'b1;
        end else ec = 1;
        if (m_cmd && lo == want_lo && pend[0] == 16'h1C15) pend.push_back(d);
        else pend.delete();
      end else begin
        if (m_bad) ec = 6;
        else if (m_data) begin
          if (d[15:12] == d[3:0] && d[11:8] == d[3:0] && d[7:4] == d[3:0]) begin
            e_str[1] = 1'b1; e_seq = d[3:0];
          end else ec = 4;
        end else ec = 5;
        pend.delete();
      end
      if (ec != 0) begin
        e_str[0] = 1'b1; e_code = 4'(ec);
      end
      if (CNT_CLEAR) begin
        e_mcnt = '0; e_ecnt = '0;
      end else begin
        if ((e_str & 9'b111110010) != '0) e_mcnt = e_mcnt + 16'd1;
        if (e_str[0] && e_ecnt != 8'd255) e_ecnt = e_ecnt + 8'd1;
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge HCLK) begin
    chk("strobes", 32'({CLOCK_MARKER, EVENT_MARKER, LOOPBACK_MARKER, DIAG_MARKER,
                        TIMEOUT_MARKER, DCS_REQUEST, UNDEF_CMD, RETRANS_REQ, ERR}), 32'(e_str));
    chk("retrans_seq", 32'(RETRANS_SEQ), 32'(e_seq));
    chk("err_code", 32'(ERR_CODE), 32'(e_code));
    chk("marker_cnt", 32'(MARKER_CNT), 32'(e_mcnt));
    chk("err_cnt", 32'(ERR_CNT), 32'(e_ecnt));
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] w, input logic [1:0] k);
    RX_DATA = w; RX_KCHAR = k;
    @(posedge HCLK); #1;
  endtask

  task automatic cmd(input logic [7:0] lo8);
    send({8'h1C, lo8}, 2'b10);
  endtask

  task automatic comma();
    send(16'hBC3C, 2'b11);
  endtask

  task automatic pulse_reset();
    HRESETN = 1'b0; #2; HRESETN = 1'b1;
  endtask

  logic [7:0] cmd_tab [0:13] = '{8'h11, 8'hEE, 8'h10, 8'hEF, 8'h15, 8'hEA, 8'h12,
                                 8'h13, 8'h14, 8'h00, 8'hED, 8'h20, 8'h11, 8'h15};

  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_err_code", 32'(ERR_CODE), 32'd0);
    chk("reset_marker_cnt", 32'(MARKER_CNT), 32'd0);
    HRESETN = 1'b1;

    repeat (6) comma();
    cmd(8'h11); cmd(8'hEE);
    chk("clock_marker", 32'(CLOCK_MARKER), 32'd1);
    chk("mcnt_after_clock", 32'(MARKER_CNT), 32'd1);
    comma();
    chk("clock_marker_one_cycle", 32'(CLOCK_MARKER), 32'd0);

    cmd(8'h15); cmd(8'hEA); send(16'h7777, 2'b00);
    chk("retrans_req", 32'(RETRANS_REQ), 32'd1);
    chk("retrans_seq7", 32'(RETRANS_SEQ), 32'd7);
    cmd(8'h15); cmd(8'hEA); send(16'h7077, 2'b00);
    chk("seq_mismatch_err", 32'({ERR, ERR_CODE}), 32'h14);
    chk("retrans_seq_held", 32'(RETRANS_SEQ), 32'd7);

    cmd(8'h10); cmd(8'h10);
    chk("repeat_first_err", 32'({ERR, ERR_CODE}), 32'h12);
    comma();
    chk("no_err_after", 32'(ERR), 32'd0);

    CNT_CLEAR = 1'b1; comma(); CNT_CLEAR = 1'b0;
    cmd(8'h11); cmd(8'hEF);
    chk("wrong_cmp", 32'(ERR_CODE), 32'd2);
    cmd(8'h15); cmd(8'hEA); comma();
    chk("missing_seq", 32'(ERR_CODE), 32'd5);
    cmd(8'h10); comma();
    chk("missing_cmp", 32'(ERR_CODE), 32'd1);
    chk("err_cnt3", 32'(ERR_CNT), 32'd3);

    cmd(8'h12);
    chk("loopback", 32'(LOOPBACK_MARKER), 32'd1);
    cmd(8'hED);
    chk("unpaired", 32'({ERR, ERR_CODE}), 32'h13);
    cmd(8'h00);
    chk("dcs", 32'(DCS_REQUEST), 32'd1);
    chk("dcs_not_counted", 32'(MARKER_CNT), 32'd1);
    cmd(8'h20);
    chk("undef", 32'({UNDEF_CMD, ERR}), 32'h2);
    send(16'h1234, 2'b10);
    chk("illegal", 32'({ERR, ERR_CODE}), 32'h16);
    cmd(8'h12); cmd(8'h12);
    chk("back_to_back", 32'(MARKER_CNT), 32'd3);

    CNT_CLEAR = 1'b1; comma(); CNT_CLEAR = 1'b0;
    for (int i = 0; i < 300; i++) send(16'(i), 2'b01);
    chk("err_cnt_sat", 32'(ERR_CNT), 32'd255);
    CNT_CLEAR = 1'b1; send(16'h0000, 2'b01); CNT_CLEAR = 1'b0;
    chk("clear_wins", 32'({ERR, ERR_CNT}), 32'h100);

    cmd(8'h15); cmd(8'hEA);
    pulse_reset();
    send(16'h7777, 2'b00);
    chk("reset_abandon", 32'({RETRANS_REQ, ERR}), 32'd0);
    chk("reset_seq", 32'(RETRANS_SEQ), 32'd0);

    // randomized stream
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      CNT_CLEAR = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 249) == 0) pulse_reset();
      if (r < 9) cmd(cmd_tab[$urandom_range(0, 13)]);
      else if (r < 11) begin
        logic [3:0] n;
        n = 4'($urandom_range(0, 15));
        send({n, n, n, n}, 2'b00);
      end else if (r < 13) send(16'($urandom), 2'b00);
      else if (r < 16) comma();
      else if (r == 16) send(16'($urandom), 2'b01);
      else if (r == 17) send(16'($urandom), 2'b11);
      else if (r == 18) send({8'h12, 8'($urandom)}, 2'b10);
      else begin
        cmd(8'h15); cmd(8'hEA);
        send(16'h5555, 2'b00);
      end
    end
    CNT_CLEAR = 1'b0;
    comma(); comma();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
